i2c_bus_arbiter: RTL and testbench

- N-way arbiter for a shared open-drain I2C bus, e.g. the QSFP management bus shared by the retimer setup master and the HDMI DDC/SCDC master.
- Generalises the fixed two-requester arbiter:
  - parametrised requester count
  - selectable round-robin or fixed priority
  - enforced bus-idle gap between owners
  - built-in wired-AND gating of each master's SCL/SDA drive
- Sits between the I2C masters and the pad iobufs, all in the system clock domain.

---
 rtl/i2c_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: N-way arbiter for a shared open-drain I2C bus.
// Round-robin or fixed-priority winner selection, an enforced idle gap
// between owners, and wired-AND gating of every master's SCL/SDA drive so
// that only the current owner can pull the bus low.
// Optional build macro ARBITER_WATCHDOG_EN adds a hold-time watchdog that
// revokes an over-long grant, pulses timeout_o and locks the offender out
// until it drops its request.
module i2c_bus_arbiter #(
    parameter int REQUEST_COUNT   = 2,
    parameter int PRIORITY_MODE   = 0,
    parameter int GAP_CYCLES      = 4,
    parameter int MAX_HOLD_CYCLES = 1_000_000,
    localparam int IW = (REQUEST_COUNT > 1) ? $clog2(REQUEST_COUNT) : 1
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic [REQUEST_COUNT-1:0] request_i,
    output logic [REQUEST_COUNT-1:0] grant_o,
    output logic [IW-1:0]            grant_index_o,
    output logic                     busy_o,
    input  logic [REQUEST_COUNT-1:0] scl_output_in_i,
    input  logic [REQUEST_COUNT-1:0] sda_output_in_i,
    output logic                     scl_output_o,
    output logic                     sda_output_o,
    output logic                     timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Last gap-counter value before returning to IDLE (unused when GAP_CYCLES = 0).
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [REQUEST_COUNT-1:0] grant_q, grant_d;
    logic [IW-1:0]            index_q, index_d;
    logic                     busy_q, busy_d;
    logic [IW-1:0]            ptr_q, ptr_d;
    logic [15:0]              gap_q, gap_d;

    logic [REQUEST_COUNT-1:0] lockout;
    logic [REQUEST_COUNT-1:0] eligible;
    logic                     found_any, found_hi, win_found;
    logic [IW-1:0]            idx_any, idx_hi, win_idx, ptr_next;
    logic [REQUEST_COUNT-1:0] win_onehot;
    logic                     owner_requesting;

`ifdef ARBITER_WATCHDOG_EN
    localparam logic [31:0] HOLD_LAST = 32'(MAX_HOLD_CYCLES - 1);

    logic [31:0]              hold_q, hold_d;
    logic [REQUEST_COUNT-1:0] lock_q, lock_d;
    logic                     timeout_q, timeout_d;

    assign lockout   = lock_q;
    assign timeout_o = timeout_q;
`else
    assign lockout   = '0;
    assign timeout_o = 1'b0;
`endif

    assign eligible         = request_i & ~lockout;
    assign owner_requesting = |(request_i & grant_q);

    // Winner selection: lowest eligible index overall, and lowest eligible
    // index at or above the round-robin pointer (wrap falls back to the former).
    always_comb begin
        found_any = 1'b0;
        found_hi  = 1'b0;
        idx_any   = '0;
        idx_hi    = '0;
        for (int i = REQUEST_COUNT - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found_any = 1'b1;
                idx_any   = IW'(i);
                if (i >= int'(ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = IW'(i);
                end
            end
        end
        win_found = found_any;
        if (PRIORITY_MODE == 1) begin
            win_idx = idx_any;
        end else begin
            win_idx = found_hi ? idx_hi : idx_any;
        end
        ptr_next = (win_idx == IW'(REQUEST_COUNT - 1)) ? '0 : win_idx + 1'b1;
        for (int i = 0; i < REQUEST_COUNT; i++) begin
            win_onehot[i] = (win_idx == IW'(i));
        end
    end

    // Next-state logic: IDLE arbitrates, GRANT holds until release (or
    // watchdog revoke), GAP enforces the idle interval between owners.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        index_d = index_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
`ifdef ARBITER_WATCHDOG_EN
        hold_d    = hold_q;
        lock_d    = lock_q & request_i;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = win_onehot;
                    index_d = win_idx;
                    busy_d  = 1'b1;
                    ptr_d   = ptr_next;
                    state_d = ST_GRANT;
`ifdef ARBITER_WATCHDOG_EN
                    hold_d  = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!owner_requesting) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
`ifdef ARBITER_WATCHDOG_EN
                else if (hold_q == HOLD_LAST) begin
                    // Revoke: the owner is still requesting, so lock it out.
                    lock_d    = lock_d | grant_q;
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    gap_d     = '0;
                    state_d   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
`endif
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            index_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            index_q <= index_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end

`ifdef ARBITER_WATCHDOG_EN
    // Watchdog hold counter, lockout mask and timeout pulse.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q    <= '0;
            lock_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            lock_q    <= lock_d;
            timeout_q <= timeout_d;
        end
    end
`endif

    assign grant_o       = grant_q;
    assign grant_index_o = index_q;
    assign busy_o        = busy_q;

    // Per-master drive gating: a master without the grant is forced released.
    logic [REQUEST_COUNT-1:0] scl_drive, sda_drive;
    for (genvar gi = 0; gi < REQUEST_COUNT; gi++) begin : g_gate
        assign scl_drive[gi] = scl_output_in_i[gi] | ~grant_q[gi];
        assign sda_drive[gi] = sda_output_in_i[gi] | ~grant_q[gi];
    end

    assign scl_output_o = &scl_drive;
    assign sda_output_o = &sda_drive;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized self-checking bench for i2c_bus_arbiter: a round-robin instance
// (GAP 3) and a fixed-priority instance (GAP 0) share random stimulus and are
// compared every cycle against a transaction-level reference model.
module tb_i2c_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 12;
    localparam int CYCLES   = 3000;
`ifdef ARBITER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req, scl_in, sda_in;

    logic [N-1:0] g_rr, g_fp;
    logic [1:0]   ix_rr, ix_fp;
    logic         b_rr, b_fp, scl_rr, scl_fp, sda_rr, sda_fp, to_rr, to_fp;

    i2c_bus_arbiter #(.REQUEST_COUNT(N), .PRIORITY_MODE(0), .GAP_CYCLES(3),
                      .MAX_HOLD_CYCLES(MAX_HOLD)) u_rr (
        .clock_i(clk), .reset_i(rst), .request_i(req), .grant_o(g_rr),
        .grant_index_o(ix_rr), .busy_o(b_rr), .scl_output_in_i(scl_in),
        .sda_output_in_i(sda_in), .scl_output_o(scl_rr), .sda_output_o(sda_rr),
        .timeout_o(to_rr));

    i2c_bus_arbiter #(.REQUEST_COUNT(N), .PRIORITY_MODE(1), .GAP_CYCLES(0),
                      .MAX_HOLD_CYCLES(MAX_HOLD)) u_fp (
        .clock_i(clk), .reset_i(rst), .request_i(req), .grant_o(g_fp),
        .grant_index_o(ix_fp), .busy_o(b_fp), .scl_output_in_i(scl_in),
        .sda_output_in_i(sda_in), .scl_output_o(scl_fp), .sda_output_o(sda_fp),
        .timeout_o(to_fp));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    // Reference model, one entry per instance: who owns the bus, how many
    // decision edges remain before arbitration is allowed, and the RR pointer.
    int           gap_len [2] = '{3, 0};
    int           mode    [2] = '{0, 1};
    int           owner   [2];
    int           last    [2];
    int           ptr     [2];
    int           wait_n  [2];
    int           held    [2];
    logic [N-1:0] lock    [2];
    logic         to_exp  [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; last[m] = 0; ptr[m] = 0; wait_n[m] = 0;
            held[m] = 0; lock[m] = '0; to_exp[m] = 1'b0;
        end
    endtask

    function automatic int pick(input int m, input logic [N-1:0] elig);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mode[m] == 1) ? k : (ptr[m] + k) % N;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int m, input logic [N-1:0] r);
        int w;
        to_exp[m] = 1'b0;
        lock[m]   = lock[m] & r;
        if (owner[m] >= 0) begin
            if (!r[owner[m]]) begin
                owner[m]  = -1;
                wait_n[m] = gap_len[m];
            end else begin
                held[m]++;
                if (WD && held[m] == MAX_HOLD) begin
                    lock[m][owner[m]] = 1'b1;
                    to_exp[m] = 1'b1;
                    owner[m]  = -1;
                    wait_n[m] = gap_len[m];
                end
            end
        end else if (wait_n[m] > 0) begin
            wait_n[m]--;
        end else begin
            w = pick(m, r & ~lock[m]);
            if (w >= 0) begin
                owner[m] = w; last[m] = w; held[m] = 0;
                ptr[m] = (w + 1) % N;
                $display("[%0t] %s grant -> master %0d (req=%b)", $time,
                         (m == 0) ? "rr" : "fp", w, r);
            end
        end
    endtask

    task automatic check_outputs(input int m, input logic [N-1:0] g, input logic [1:0] ix,
                                 input logic b, input logic s, input logic d, input logic t);
        string nm;
        logic [N-1:0] eg;
        nm = (m == 0) ? "rr" : "fp";
        eg = (owner[m] >= 0) ? (N'(1) << owner[m]) : '0;
        check_val({nm, ".grant"}, 32'(g), 32'(eg));
        check_val({nm, ".grant_index"}, 32'(ix), 32'(last[m]));
        check_val({nm, ".busy"}, 32'(b), 32'(owner[m] >= 0));
        check_val({nm, ".scl"}, 32'(s), (owner[m] >= 0) ? 32'(scl_in[owner[m]]) : 32'd1);
        check_val({nm, ".sda"}, 32'(d), (owner[m] >= 0) ? 32'(sda_in[owner[m]]) : 32'd1);
        check_val({nm, ".timeout"}, 32'(t), 32'(to_exp[m]));
    endtask

    initial begin
        rst = 1'b1; req = '0; scl_in = '0; sda_in = '0;
        model_reset();
        @(negedge clk);
        // Reset state with every master driving low: bus must read released.
        check_outputs(0, g_rr, ix_rr, b_rr, scl_rr, sda_rr, to_rr);
        check_outputs(1, g_fp, ix_fp, b_fp, scl_fp, sda_fp, to_fp);
        rst = 1'b0;

        for (cyc = 0; cyc < CYCLES; cyc++) begin
            @(negedge clk);
            check_outputs(0, g_rr, ix_rr, b_rr, scl_rr, sda_rr, to_rr);
            check_outputs(1, g_fp, ix_fp, b_fp, scl_fp, sda_fp, to_fp);

            if (cyc == CYCLES / 2) begin
                // Asynchronous reset between edges while requests are active.
                req = '1;
                @(negedge clk);
                model_step(0, req); model_step(1, req);
                #2 rst = 1'b1;
                #1;
                check_val("rr.async_grant", 32'(g_rr), 32'd0);
                check_val("rr.async_busy", 32'(b_rr), 32'd0);
                check_val("fp.async_grant", 32'(g_fp), 32'd0);
                check_val("fp.async_busy", 32'(b_fp), 32'd0);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                check_outputs(0, g_rr, ix_rr, b_rr, scl_rr, sda_rr, to_rr);
                check_outputs(1, g_fp, ix_fp, b_fp, scl_fp, sda_fp, to_fp);
            end

            // Sticky requests (occasional toggles) so grants last several cycles.
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            end
            scl_in = N'($urandom);
            sda_in = N'($urandom);

            @(posedge clk);
            model_step(0, req);
            model_step(1, req);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
